// File: rtl/ipdom_warp_stack_pkg.sv
// Shared width helpers for the multi-warp IPDOM reconvergence stack.
// Latency: n/a; backpressure: n/a.
package ipdom_pkg;

  function automatic int ipdom_widw(input int num_warps);
    return (num_warps > 1) ? $clog2(num_warps) : 1;
  endfunction

  function automatic int ipdom_cntw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ipdom_warp_stack_if.sv
// Scheduler-facing split/join port bundle of the IPDOM stack.
// Latency: pop response one cycle after request; backpressure: none, illegal ops are flagged.
interface ipdom_warp_stack_if #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int NUM_WARPS = 4
);
  import ipdom_pkg::*;
  localparam int WIDW = ipdom_widw(NUM_WARPS);
  localparam int CNTW = ipdom_cntw(DEPTH);

  logic                 push_i;
  logic                 pop_i;
  logic [WIDW-1:0]      wid_i;
  logic                 pair_i;
  logic [WIDTH-1:0]     q1_i;
  logic [WIDTH-1:0]     q2_i;
  logic                 clear_err_i;
  logic                 rsp_valid_o;
  logic [WIDW-1:0]      rsp_wid_o;
  logic [WIDTH-1:0]     rsp_data_o;
  logic                 rsp_index_o;
  logic [CNTW-1:0]      level_o;
  logic [NUM_WARPS-1:0] empty_o;
  logic [NUM_WARPS-1:0] full_o;
  logic                 overflow_o;
  logic                 underflow_o;
  logic                 conflict_o;

  modport master (
    output push_i, pop_i, wid_i, pair_i, q1_i, q2_i, clear_err_i,
    input  rsp_valid_o, rsp_wid_o, rsp_data_o, rsp_index_o, level_o, empty_o, full_o,
           overflow_o, underflow_o, conflict_o
  );

  modport slave (
    input  push_i, pop_i, wid_i, pair_i, q1_i, q2_i, clear_err_i,
    output rsp_valid_o, rsp_wid_o, rsp_data_o, rsp_index_o, level_o, empty_o, full_o,
           overflow_o, underflow_o, conflict_o
  );
endinterface

// File: rtl/double_port_mem_wrapper.sv
// One write port, one read port storage; read is combinational when OUT_REG=0, else registered.
// Latency: 0 or 1 cycle read; backpressure: none.
module double_port_mem_wrapper #(
  parameter int SIZE    = 32,
  parameter int DATAW   = 64,
  parameter bit OUT_REG = 1'b0,
  localparam int AW     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             wren,
  input  logic [AW-1:0]    waddr,
  input  logic [DATAW-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [DATAW-1:0] rdata
);
  logic [DATAW-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (wren) mem[waddr] <= wdata;
  end

  generate
    if (OUT_REG) begin : g_reg
      logic [DATAW-1:0] rdata_q;
      always_ff @(posedge clk) rdata_q <= mem[raddr];
      assign rdata = rdata_q;
    end else begin : g_comb
      assign rdata = mem[raddr];
    end
  endgenerate
endmodule

// File: rtl/ipdom_warp_ctrl.sv
// Per-warp occupancy counter and part-consumed bits of one IPDOM stack.
// Latency: state updates on the op edge; backpressure: caller gates push_en/pop_en.
module ipdom_warp_ctrl #(
  parameter int DEPTH    = 8,
  localparam int ADDRW   = $clog2(DEPTH),
  localparam int CNTW    = ADDRW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_en,
  input  logic            pop_en,
  input  logic            pair,
  output logic [CNTW-1:0] cnt,
  output logic            top_part
);
  logic [DEPTH-1:0] part;
  logic [ADDRW-1:0] wptr;
  logic [ADDRW-1:0] tptr;

  assign wptr     = cnt[ADDRW-1:0];
  assign tptr     = wptr - ADDRW'(1);
  assign top_part = part[tptr];

  // A split pair needs two pops: first returns q2 and marks the entry, second returns q1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt  <= '0;
      part <= '0;
    end else if (push_en) begin
      part[wptr] <= ~pair;
      cnt        <= cnt + CNTW'(1);
    end else if (pop_en) begin
      if (part[tptr]) cnt <= cnt - CNTW'(1);
      else            part[tptr] <= 1'b1;
    end
  end
endmodule

// File: rtl/ipdom_warp_stack.sv
// NUM_WARPS IPDOM reconvergence stacks sharing one memory, addressed {warp, ptr}.
// Latency: pop response registered, 1 cycle; backpressure: none, full/empty misuse sets sticky flags.
module ipdom_warp_stack
  import ipdom_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int NUM_WARPS = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ipdom_warp_stack_if.slave  bus
);
  localparam int ADDRW = $clog2(DEPTH);
  localparam int WIDW  = ipdom_widw(NUM_WARPS);
  localparam int CNTW  = ipdom_cntw(DEPTH);
  localparam int SIZE  = NUM_WARPS * DEPTH;
  localparam int MEMAW = $clog2(SIZE);

  // Entry/response widths follow this instance's WIDTH, so the structs live here.
  typedef struct packed {
    logic [WIDTH-1:0] q2;
    logic [WIDTH-1:0] q1;
  } ipdom_entry_t;

  typedef struct packed {
    logic             valid;
    logic [WIDW-1:0]  wid;
    logic             index;
    logic [WIDTH-1:0] data;
  } ipdom_rsp_t;

  logic [CNTW-1:0]      cnt [NUM_WARPS];
  logic [NUM_WARPS-1:0] top_part;
  logic [WIDW-1:0]      wsel;
  logic [CNTW-1:0]      sel_cnt;
  logic                 sel_full, sel_empty, sel_part;
  logic                 do_pop, push_ok, pop_ok;
  logic [ADDRW-1:0]     wr_ptr, rd_ptr;
  ipdom_entry_t         wr_entry, rd_entry;
  ipdom_rsp_t           rsp;
  logic                 overflow_q, underflow_q, conflict_q;

  assign wsel      = (NUM_WARPS > 1) ? bus.wid_i : '0;
  assign sel_cnt   = cnt[wsel];
  assign sel_part  = top_part[wsel];
  assign sel_full  = (sel_cnt == CNTW'(DEPTH));
  assign sel_empty = (sel_cnt == '0);
  assign do_pop    = bus.pop_i & ~bus.push_i;
  assign push_ok   = bus.push_i & ~sel_full;
  assign pop_ok    = do_pop & ~sel_empty;

  generate
    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
      ipdom_warp_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_en  (push_ok && (wsel == WIDW'(w))),
        .pop_en   (pop_ok && (wsel == WIDW'(w))),
        .pair     (bus.pair_i),
        .cnt      (cnt[w]),
        .top_part (top_part[w])
      );
      assign bus.empty_o[w] = (cnt[w] == '0);
      assign bus.full_o[w]  = (cnt[w] == CNTW'(DEPTH));
    end
  endgenerate

  assign wr_ptr   = sel_cnt[ADDRW-1:0];
  assign rd_ptr   = wr_ptr - ADDRW'(1);
  assign wr_entry = '{q2: bus.q2_i, q1: bus.q1_i};

  double_port_mem_wrapper #(
    .SIZE    (SIZE),
    .DATAW   (2 * WIDTH),
    .OUT_REG (1'b0)
  ) u_mem (
    .clk   (clk_i),
    .wren  (push_ok),
    .waddr (MEMAW'({wsel, wr_ptr})),
    .wdata (wr_entry),
    .raddr (MEMAW'({wsel, rd_ptr})),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp <= '0;
    end else begin
      rsp.valid <= pop_ok;
      if (pop_ok) begin
        rsp.wid   <= wsel;
        rsp.index <= sel_part;
        rsp.data  <= sel_part ? rd_entry.q1 : rd_entry.q2;
      end
    end
  end

  // Clear is applied first so a same-cycle event still leaves the flag set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      overflow_q  <= (bus.push_i & sel_full) | (overflow_q & ~bus.clear_err_i);
      underflow_q <= (do_pop & sel_empty) | (underflow_q & ~bus.clear_err_i);
      conflict_q  <= (bus.push_i & bus.pop_i) | (conflict_q & ~bus.clear_err_i);
    end
  end

  assign bus.rsp_valid_o = rsp.valid;
  assign bus.rsp_wid_o   = rsp.wid;
  assign bus.rsp_index_o = rsp.index;
  assign bus.rsp_data_o  = rsp.data;
  assign bus.level_o     = sel_cnt;
  assign bus.overflow_o  = overflow_q;
  assign bus.underflow_o = underflow_q;
  assign bus.conflict_o  = conflict_q;
endmodule

// File: tb/tb_ipdom_warp_stack.sv
// Bench for ipdom_warp_stack: directed walk-through plus random traffic against a queue-based model.
module tb_ipdom_warp_stack;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int NW = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  ipdom_warp_stack_if #(.WIDTH(W), .DEPTH(D), .NUM_WARPS(NW)) bus ();

  ipdom_warp_stack #(.WIDTH(W), .DEPTH(D), .NUM_WARPS(NW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: each warp is a queue of pending entries; 'used' means the q2 half is already returned.
  typedef struct {
    logic [W-1:0] q2;
    logic [W-1:0] q1;
    bit           used;
  } ent_t;

  ent_t         stk [NW][$];
  bit           m_vld, m_idx, m_ovf, m_udf, m_cfl;
  logic [1:0]   m_wid;
  logic [W-1:0] m_data;
  int           mw, mt;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < NW; w++) stk[w].delete();
      m_vld = 0; m_idx = 0; m_wid = '0; m_data = '0;
      m_ovf = 0; m_udf = 0; m_cfl = 0;
    end else begin
      mw    = int'(bus.wid_i);
      m_vld = 0;
      if (bus.clear_err_i) begin
        m_ovf = 0; m_udf = 0; m_cfl = 0;
      end
      if (bus.push_i) begin
        if (bus.pop_i) m_cfl = 1;
        if (stk[mw].size() < D) stk[mw].push_back('{q2: bus.q2_i, q1: bus.q1_i, used: !bus.pair_i});
        else m_ovf = 1;
      end else if (bus.pop_i) begin
        if (stk[mw].size() == 0) m_udf = 1;
        else begin
          mt     = stk[mw].size() - 1;
          m_vld  = 1;
          m_wid  = 2'(mw);
          m_idx  = stk[mw][mt].used;
          m_data = stk[mw][mt].used ? stk[mw][mt].q1 : stk[mw][mt].q2;
          if (stk[mw][mt].used) void'(stk[mw].pop_back());
          else stk[mw][mt].used = 1;
        end
      end
    end
  end

  logic [NW-1:0] exp_empty, exp_full;
  always @(negedge clk_i) begin
    if (rst_ni) begin
      for (int w = 0; w < NW; w++) begin
        exp_empty[w] = (stk[w].size() == 0);
        exp_full[w]  = (stk[w].size() == D);
      end
      check("cmp_rsp_valid", 64'(bus.rsp_valid_o), 64'(m_vld));
      check("cmp_rsp_wid",   64'(bus.rsp_wid_o),   64'(m_wid));
      check("cmp_rsp_data",  64'(bus.rsp_data_o),  64'(m_data));
      check("cmp_rsp_index", 64'(bus.rsp_index_o), 64'(m_idx));
      check("cmp_level",     64'(bus.level_o),     64'(stk[bus.wid_i].size()));
      check("cmp_empty",     64'(bus.empty_o),     64'(exp_empty));
      check("cmp_full",      64'(bus.full_o),      64'(exp_full));
      check("cmp_overflow",  64'(bus.overflow_o),  64'(m_ovf));
      check("cmp_underflow", 64'(bus.underflow_o), 64'(m_udf));
      check("cmp_conflict",  64'(bus.conflict_o),  64'(m_cfl));
    end
  end

  task automatic op(input bit push, input bit pop, input int w, input bit pair,
                    input logic [W-1:0] q2, input logic [W-1:0] q1, input bit clr);
    bus.push_i = push; bus.pop_i = pop; bus.wid_i = 2'(w); bus.pair_i = pair;
    bus.q2_i = q2; bus.q1_i = q1; bus.clear_err_i = clr;
    @(posedge clk_i); #1;
    bus.push_i = 1'b0; bus.pop_i = 1'b0; bus.clear_err_i = 1'b0;
  endtask

  task automatic pop_expect(input int w, input logic [W-1:0] data, input bit idx, input int lvl);
    op(0, 1, w, 0, '0, '0, 0);
    check("pop_valid", 64'(bus.rsp_valid_o), 64'd1);
    check("pop_wid",   64'(bus.rsp_wid_o),   64'(w));
    check("pop_data",  64'(bus.rsp_data_o),  64'(data));
    check("pop_index", 64'(bus.rsp_index_o), 64'(idx));
    check("pop_level", 64'(bus.level_o),     64'(lvl));
  endtask

  int thr, r;
  initial begin
    bus.push_i = 0; bus.pop_i = 0; bus.wid_i = '0; bus.pair_i = 0;
    bus.q1_i = '0; bus.q2_i = '0; bus.clear_err_i = 0;
    #12;
    check("rst_empty", 64'(bus.empty_o), 64'hf);
    check("rst_full",  64'(bus.full_o),  64'h0);
    check("rst_level", 64'(bus.level_o), 64'h0);
    check("rst_valid", 64'(bus.rsp_valid_o), 64'h0);
    check("rst_errs",  64'({bus.overflow_o, bus.underflow_o, bus.conflict_o}), 64'h0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Split pair on warp 1: q2 first, then q1.
    op(1, 0, 1, 1, 32'hA, 32'hB, 0);
    check("w1_level_push", 64'(bus.level_o), 64'd1);
    pop_expect(1, 32'hA, 1'b0, 1);
    pop_expect(1, 32'hB, 1'b1, 0);
    check("w1_empty", 64'(bus.empty_o[1]), 64'd1);

    // Single entries on warp 2 return their q1 half in LIFO order.
    for (int i = 1; i <= 3; i++) op(1, 0, 2, 0, 32'hFFFF_0000, 32'(i), 0);
    check("w2_level3", 64'(bus.level_o), 64'd3);
    for (int w = 0; w < NW; w++) begin
      if (w != 2) begin
        bus.wid_i = 2'(w); #1;
        check("w2_others_level", 64'(bus.level_o), 64'd0);
      end
    end
    for (int i = 3; i >= 1; i--) pop_expect(2, 32'(i), 1'b1, i - 1);

    // Fill warp 0, then overflow.
    for (int i = 0; i < D; i++) op(1, 0, 0, 0, '0, 32'h100 + 32'(i), 0);
    check("w0_full", 64'(bus.full_o), 64'h1);
    op(1, 0, 0, 0, '0, 32'hDEAD, 0);
    check("w0_overflow", 64'(bus.overflow_o), 64'd1);
    check("w0_level8",   64'(bus.level_o),    64'd8);
    pop_expect(0, 32'h107, 1'b1, 7);

    // Underflow on warp 3, clear, then push+pop conflict.
    op(0, 1, 3, 0, '0, '0, 0);
    check("w3_no_rsp",    64'(bus.rsp_valid_o), 64'd0);
    check("w3_underflow", 64'(bus.underflow_o), 64'd1);
    op(0, 0, 3, 0, '0, '0, 1);
    check("w3_cleared", 64'({bus.overflow_o, bus.underflow_o}), 64'd0);
    op(1, 1, 3, 0, '0, 32'h33, 0);
    check("w3_conflict",  64'(bus.conflict_o),  64'd1);
    check("w3_push_done", 64'(bus.level_o),     64'd1);
    check("w3_pop_ign",   64'(bus.rsp_valid_o), 64'd0);

    // Bring warp 0 to level 5, then assert reset asynchronously.
    pop_expect(0, 32'h106, 1'b1, 6);
    pop_expect(0, 32'h105, 1'b1, 5);
    #2; rst_ni = 1'b0; #1;
    check("arst_level", 64'(bus.level_o),     64'd0);
    check("arst_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("arst_empty", 64'(bus.empty_o),     64'hf);
    check("arst_conf",  64'(bus.conflict_o),  64'd0);
    #7;
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Random traffic, alternating push-heavy and pop-heavy phases to reach both extremes.
    for (int i = 0; i < 2400; i++) begin
      thr = ((i / 300) % 2 == 0) ? 65 : 28;
      r   = $urandom_range(0, 99);
      bus.wid_i       = 2'($urandom_range(0, NW - 1));
      bus.pair_i      = 1'($urandom_range(0, 1));
      bus.q2_i        = $urandom;
      bus.q1_i        = $urandom;
      bus.push_i      = (r < thr) || (r >= 95 && r < 97);
      bus.pop_i       = (r >= thr && r < 97);
      bus.clear_err_i = ($urandom_range(0, 39) == 0);
      @(posedge clk_i); #1;
    end
    bus.push_i = 0; bus.pop_i = 0; bus.clear_err_i = 0;
    @(posedge clk_i); #1;
    @(negedge clk_i); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
